// File: rtl/avm_arb_pkg.sv
// Shared types and defaults for the two-client Avalon-MM read arbiter.
package avm_arb_pkg;

  localparam int DEFAULT_ADDR_W = 32;
  localparam int DEFAULT_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant logic; purely combinational, pointer held by the caller.
module rr_arb2 (
  input  logic req0,
  input  logic req1,
  input  logic last_grant,
  output logic gnt_valid,
  output logic gnt_idx
);

  always_comb begin
    gnt_valid = req0 | req1;
    // On a tie the client that did not win last time goes first.
    gnt_idx   = (req0 && req1) ? ~last_grant : req1;
  end

endmodule

// File: rtl/avm_read_arbiter.sv
// Arbitrates two read clients onto one Avalon-MM master, one outstanding read at a time.
module avm_read_arbiter
  import avm_arb_pkg::*;
#(
  parameter int ADDR_W = DEFAULT_ADDR_W,
  parameter int DATA_W = DEFAULT_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  output logic              done0,
  output logic              done1,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic [ADDR_W-1:0] master_address,
  output logic              master_read,
  input  logic              master_waitrequest,
  input  logic [DATA_W-1:0] master_readdata,
  input  logic              master_readdatavalid
);

  state_t              state_reg, state_next;
  logic                grant_reg, grant_next;
  logic                last_grant_reg, last_grant_next;
  logic [ADDR_W-1:0]   address_next;
  logic                read_next;
  logic [DATA_W-1:0]   rdata_next;
  logic                done0_next, done1_next;
  logic                gnt_valid, gnt_idx;

  rr_arb2 u_arb (
    .req0       (req0),
    .req1       (req1),
    .last_grant (last_grant_reg),
    .gnt_valid  (gnt_valid),
    .gnt_idx    (gnt_idx)
  );

  assign busy = (state_reg != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg      <= IDLE;
      grant_reg      <= 1'b0;
      last_grant_reg <= 1'b1;
      master_address <= '0;
      master_read    <= 1'b0;
      rdata          <= '0;
      done0          <= 1'b0;
      done1          <= 1'b0;
    end else begin
      state_reg      <= state_next;
      grant_reg      <= grant_next;
      last_grant_reg <= last_grant_next;
      master_address <= address_next;
      master_read    <= read_next;
      rdata          <= rdata_next;
      done0          <= done0_next;
      done1          <= done1_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    grant_next      = grant_reg;
    last_grant_next = last_grant_reg;
    address_next    = master_address;
    read_next       = master_read;
    rdata_next      = rdata;
    done0_next      = 1'b0;
    done1_next      = 1'b0;
    case (state_reg)
      IDLE: begin
        if (gnt_valid) begin
          grant_next      = gnt_idx;
          last_grant_next = gnt_idx;
          address_next    = gnt_idx ? addr1 : addr0;
          read_next       = 1'b1;
          state_next      = REQ;
        end
      end
      REQ: begin
        if (!master_waitrequest) begin
          read_next  = 1'b0;
          state_next = WAIT;
        end
      end
      WAIT: begin
        // No timeout: a slave that never answers keeps the arbiter here until reset.
        if (master_readdatavalid) begin
          rdata_next = master_readdata;
          done0_next = ~grant_reg;
          done1_next = grant_reg;
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_avm_read_arbiter.sv
// Self-checking bench: directed scenarios plus a randomized phase against a transaction-level model.
module tb_avm_read_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          req0, req1;
  logic [AW-1:0] addr0, addr1;
  logic          done0, done1;
  logic [DW-1:0] rdata;
  logic          busy;
  logic [AW-1:0] master_address;
  logic          master_read;
  logic          master_waitrequest;
  logic [DW-1:0] master_readdata;
  logic          master_readdatavalid;

  always #5 clk = ~clk;

  avm_read_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk                  (clk),
    .reset                (reset),
    .req0                 (req0),
    .req1                 (req1),
    .addr0                (addr0),
    .addr1                (addr1),
    .done0                (done0),
    .done1                (done1),
    .rdata                (rdata),
    .busy                 (busy),
    .master_address       (master_address),
    .master_read          (master_read),
    .master_waitrequest   (master_waitrequest),
    .master_readdata      (master_readdata),
    .master_readdatavalid (master_readdatavalid)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Transaction-level reference: one read in flight, served in round-robin order.
  bit        m_active, m_accepted, m_finishing;
  int        m_winner, m_ptr;
  logic [31:0] m_rdata, m_addr;
  bit        e_done0, e_done1;

  // Slave responder and bookkeeping.
  int        wait_cfg, wait_left, lat_cfg, lat_left;
  logic [31:0] next_data;
  bit        noise;
  int        mr_cnt, acc_cnt;

  bit        s_req0, s_req1, s_wr, s_rdv, s_mr;
  logic [31:0] s_addr0, s_addr1, s_data;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%h exp=%h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_active = 0; m_accepted = 0; m_finishing = 0;
    m_winner = 0; m_ptr = 1;
    m_rdata = '0; m_addr = '0;
    e_done0 = 0; e_done1 = 0;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, "_done0"}, 32'(done0), 32'(e_done0));
    check({tag, "_done1"}, 32'(done1), 32'(e_done1));
    check({tag, "_rdata"}, rdata, m_rdata);
    check({tag, "_maddr"}, master_address, m_addr);
    check({tag, "_mread"}, 32'(master_read), 32'(m_active && !m_accepted));
    check({tag, "_busy"},  32'(busy), 32'(m_active));
  endtask

  task automatic cycle(input string tag);
    s_req0 = req0; s_req1 = req1; s_addr0 = addr0; s_addr1 = addr1;
    s_wr = master_waitrequest; s_rdv = master_readdatavalid; s_data = master_readdata;
    s_mr = master_read;
    @(posedge clk);
    #1;
    cyc++;
    e_done0 = 0; e_done1 = 0;
    if (m_finishing) begin
      m_finishing = 0;
      m_active    = 0;
    end else if (!m_active) begin
      if (s_req0 || s_req1) begin
        if (s_req0 && s_req1) m_winner = 1 - m_ptr;
        else                  m_winner = s_req1 ? 1 : 0;
        m_ptr      = m_winner;
        m_active   = 1;
        m_accepted = 0;
        m_addr     = (m_winner == 1) ? s_addr1 : s_addr0;
      end
    end else if (!m_accepted) begin
      if (!s_wr) m_accepted = 1;
    end else if (s_rdv) begin
      m_rdata = s_data;
      if (m_winner == 0) e_done0 = 1; else e_done1 = 1;
      m_finishing = 1;
    end
    check_outputs(tag);
    if (master_read) mr_cnt++;
    if (e_done0) req0 = 1'b0;
    if (e_done1) req1 = 1'b0;
    // Slave: returns data lat_cfg cycles after accepting, stalls wait_cfg cycles per read.
    if (s_mr && !s_wr) begin
      lat_left = lat_cfg;
      acc_cnt++;
    end
    master_readdatavalid = 1'b0;
    master_readdata      = $urandom;
    if (lat_left > 0) begin
      lat_left--;
      if (lat_left == 0) begin
        master_readdatavalid = 1'b1;
        master_readdata      = next_data;
      end
    end
    if (master_read) begin
      if (!s_mr) wait_left = wait_cfg;
      master_waitrequest = (wait_left > 0);
      if (wait_left > 0) wait_left--;
    end else begin
      master_waitrequest = noise ? 1'($urandom_range(0, 1)) : 1'b0;
    end
    if (noise && $urandom_range(0, 7) == 0) begin
      master_readdatavalid = 1'b1;
      master_readdata      = $urandom;
    end
  endtask

  task automatic wait_done(input string tag, input int who);
    int n = 0;
    bit seen = 0;
    while (!seen && n < 40) begin
      cycle(tag);
      n++;
      seen = (who == 0) ? done0 : done1;
    end
    check({tag, "_done_seen"}, 32'(seen), 32'd1);
  endtask

  task automatic wait_any(input string tag, output int who);
    int n = 0;
    bit seen = 0;
    who = -1;
    while (!seen && n < 40) begin
      cycle(tag);
      n++;
      seen = done0 | done1;
    end
    check({tag, "_any_done"}, 32'(seen), 32'd1);
    if (seen) who = done1 ? 1 : 0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req0 = 1'b0; req1 = 1'b0; addr0 = '0; addr1 = '0;
    master_waitrequest = 1'b0; master_readdatavalid = 1'b0; master_readdata = '0;
    wait_left = 0; lat_left = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_outputs("reset");
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    int start, d1, who, n;
    int order[4];
    int exp_order[4];
    exp_order = '{0, 1, 0, 1};
    noise = 0; mr_cnt = 0; acc_cnt = 0;
    wait_cfg = 0; lat_cfg = 1; next_data = '0;

    // Single read, zero wait, one-cycle latency.
    do_reset();
    next_data = 32'hDEADBEEF;
    addr0 = 32'h100; req0 = 1'b1;
    start = cyc; mr_cnt = 0;
    wait_done("t1", 0);
    check("t1_latency", 32'(cyc - start), 32'd3);
    check("t1_rdata", rdata, 32'hDEADBEEF);
    check("t1_addr", master_address, 32'h100);
    check("t1_mread_cycles", 32'(mr_cnt), 32'd1);
    cycle("t1");

    // Waitrequest held for three cycles.
    wait_cfg = 3; next_data = 32'h1234_5678;
    addr1 = 32'h200; req1 = 1'b1;
    mr_cnt = 0; acc_cnt = 0;
    wait_done("t2", 1);
    check("t2_mread_cycles", 32'(mr_cnt), 32'd4);
    check("t2_accepts", 32'(acc_cnt), 32'd1);
    check("t2_addr", master_address, 32'h200);
    cycle("t2");

    // Simultaneous requests re-raised after each done: strict alternation.
    do_reset();
    wait_cfg = 0; lat_cfg = 1;
    addr0 = 32'h1000; addr1 = 32'h2000; req0 = 1'b1; req1 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      next_data = 32'hA000_0000 + 32'(k);
      wait_any("t3", who);
      order[k] = who;
      cycle("t3");
      if (k < 3) begin
        if (who == 0) begin addr0 = addr0 + 32'd4; req0 = 1'b1; end
        else          begin addr1 = addr1 + 32'd4; req1 = 1'b1; end
      end
    end
    for (int k = 0; k < 4; k++) check("t3_order", 32'(order[k]), 32'(exp_order[k]));
    wait_any("t3_drain", who);
    cycle("t3_drain");

    // Stray readdatavalid in IDLE, REQ and DONE is ignored.
    master_readdatavalid = 1'b1; master_readdata = 32'h0BAD_0001;
    cycle("t4_idle");
    cycle("t4_idle");
    wait_cfg = 3; next_data = 32'hCAFE_F00D;
    addr0 = 32'h180; req0 = 1'b1;
    cycle("t4_start");
    master_readdatavalid = 1'b1; master_readdata = 32'h0BAD_0002;
    cycle("t4_req");
    wait_done("t4", 0);
    master_readdatavalid = 1'b1; master_readdata = 32'h0BAD_0003;
    cycle("t4_done");
    cycle("t4_idle2");
    check("t4_rdata", rdata, 32'hCAFE_F00D);

    // Asynchronous reset while waiting for read data.
    wait_cfg = 0; lat_cfg = 4; next_data = 32'h5555_AAAA;
    addr0 = 32'h300; req0 = 1'b1;
    cycle("t5");
    cycle("t5");
    cycle("t5_wait");
    #2;
    reset = 1'b1;
    req0 = 1'b0;
    model_reset();
    #1;
    check_outputs("t5_async");
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 6; k++) cycle("t5_after");

    // Request arriving while the other client's read is in flight.
    wait_cfg = 0; lat_cfg = 3; next_data = 32'h7777_0001;
    addr1 = 32'h400; req1 = 1'b1;
    cycle("t6");
    cycle("t6");
    addr0 = 32'h500; req0 = 1'b1;
    wait_done("t6_c1", 1);
    d1 = cyc;
    n = 0;
    while (!master_read && n < 10) begin
      cycle("t6_gap");
      n++;
    end
    check("t6_start_gap", 32'(cyc - d1), 32'd2);
    check("t6_addr", master_address, 32'h500);
    next_data = 32'h7777_0002;
    wait_done("t6_c0", 0);
    cycle("t6");

    // Randomized traffic with bus noise.
    noise = 1;
    for (int k = 0; k < 400; k++) begin
      if (!req0 && !e_done0 && $urandom_range(0, 3) == 0) begin req0 = 1'b1; addr0 = $urandom; end
      if (!req1 && !e_done1 && $urandom_range(0, 3) == 0) begin req1 = 1'b1; addr1 = $urandom; end
      wait_cfg  = $urandom_range(0, 2);
      lat_cfg   = $urandom_range(1, 3);
      next_data = $urandom;
      cycle("rand");
    end
    noise = 0;
    for (int k = 0; k < 40; k++) cycle("drain");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
